// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives 0..2**N_IN-1 onto a combinational block, settles, and captures its output.
// Optional build macro TTS_COMPARE_EN adds ref_o and a dut_o/ref_o mismatch counter.
module truth_table_sweeper #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_o,
`ifdef TTS_COMPARE_EN
  input  logic                 ref_o,
  output logic [N_IN:0]        mismatch,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt
);

  localparam int unsigned TT_W  = 2**N_IN;
  localparam int unsigned CNT_W = 4;
  localparam logic [N_IN-1:0]  LAST_VEC   = N_IN'(TT_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC);
`ifdef TTS_COMPARE_EN
  localparam logic [N_IN:0]    MM_MAX     = (N_IN+1)'(TT_W);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Sweep sequencer; abort outranks every non-idle action, including the sample write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      cnt      <= '0;
`ifdef TTS_COMPARE_EN
      mismatch <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        stim  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_HOLD;
              stim     <= '0;
              tt       <= '0;
              busy     <= 1'b1;
              cnt      <= SETTLE_VAL;
`ifdef TTS_COMPARE_EN
              mismatch <= '0;
`endif
            end
          end
          S_HOLD: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           state <= S_SAMPLE;
          end
          S_SAMPLE: begin
            tt[stim] <= dut_o;
`ifdef TTS_COMPARE_EN
            if ((dut_o != ref_o) && (mismatch != MM_MAX))
              mismatch <= mismatch + (N_IN+1)'(1);
`endif
            // Terminal vector ends the sweep instead of wrapping stim.
            if (stim == LAST_VEC) begin
              state <= S_DONE;
            end else begin
              stim  <= stim + N_IN'(1);
              cnt   <= SETTLE_VAL;
              state <= S_HOLD;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            stim  <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
